sprite_fetch_arbiter: RTL and testbench
=======================================

SPRITE_FETCH_ARBITER -- requirements
Module: sprite_fetch_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of sprite requesters (0 = guy, 1..3 = trophy0..2).
REQ-002 The block SHALL have parameter AW, default 9, giving the sprite ROM address width (18x18 = 324 words).
REQ-003 The block SHALL have parameter DW, default 12, giving the pixel width in RGB444.
REQ-004 The block SHALL have parameter ROM_LAT, default 1, giving the ROM read latency in cycles (legal values 1..2).
REQ-005 clk  in  1  pixel clock (clk_25MHz domain).
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 req  in  N_REQ  per-requester fetch request, held until granted.
REQ-008 req_addr  in  N_REQ*AW  packed addresses; slice i belongs to requester i.
REQ-009 req_mask  in  N_REQ  enable per requester (from trophy_cnt / game_state); 0 blocks grants.
REQ-010 frame_start  in  1  one-cycle pulse at the vsync boundary.
REQ-011 gnt  out  N_REQ  one-hot acceptance, combinational, same cycle as req.
REQ-012 rom_en, rom_addr  out  1, AW  registered shared-ROM port.
REQ-013 rom_data  in  DW  ROM read data, valid ROM_LAT cycles after rom_en.
REQ-014 rsp_valid, rsp_id, rsp_data  out  1, clog2(N_REQ), DW  return of fetched pixel with owner id.

Function
REQ-015 The block SHALL grant at most one requester per cycle; a grant occurs iff the requester has req[i]&req_mask[i]=1 and frame_start=0.
REQ-016 Arbitration SHALL be round-robin: the search starts at pointer ptr and wraps from N_REQ-1 to 0.
REQ-017 After a grant to requester i, ptr SHALL become (i+1) mod N_REQ on the next cycle; with no grant, ptr SHALL hold.
REQ-018 A grant in cycle N SHALL produce rom_en=1 and rom_addr=req_addr[i] in cycle N+1; with no grant, rom_en SHALL be 0 and rom_addr SHALL hold.
REQ-019 The id SHALL travel in a ROM_LAT-deep valid/id shift pipeline; rsp_valid=1 with rsp_id=i and rsp_data=rom_data SHALL appear in cycle N+1+ROM_LAT.
REQ-020 The block SHALL sustain one response per cycle with back-to-back grants; no bubbles SHALL be inserted.
REQ-021 frame_start SHALL reset ptr to 0 and suppress grants in that cycle; in-flight responses SHALL still complete.
REQ-022 If a requester's mask drops while its req is pending, that request SHALL NOT be granted until the mask returns; in-flight responses for it SHALL still be delivered.
REQ-023 When rsp_valid=0, rsp_id and rsp_data SHALL hold their last values.

Reset
REQ-024 On rst_n low, the block SHALL asynchronously set ptr=0, rom_en=0, rom_addr=0, all pipeline valids=0, rsp_valid=0, rsp_id=0, rsp_data=0; gnt follows from the zero state.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight fetches, with no response after release.
REQ-026 The first grant after reset release SHALL go to the lowest-index eligible requester.

Configuration
REQ-027 Macro SPRITE_FETCH_ARBITER_PERF_EN: when defined, the block SHALL add output conflict_cnt (16 bit), incremented by 1 in each cycle where two or more eligible requesters are pending, saturating at 0xFFFF, cleared by reset and by frame_start.
REQ-028 When the macro is undefined, the conflict_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package sprite_arb_pkg SHALL hold N_REQ, AW, DW, the ID_W constant, requester-index localparams (REQ_GUY, REQ_TROPHY0..2) and the id typedef.
REQ-030 Sub-module rr_pick SHALL implement the pure combinational round-robin picker (inputs: eligible vector and ptr; outputs: one-hot grant and index); all state SHALL live in sprite_fetch_arbiter.

Verification
REQ-031 Single request: after reset, req=0001, mask=1111, addr0=0x005 -> gnt=0001 in cycle 0; rom_en=1 with rom_addr=0x005 in cycle 1; rsp_valid=1 with rsp_id=0 in cycle 1+ROM_LAT.
REQ-032 All four requesting continuously with mask=1111 -> grant order 0,1,2,3,0,... with one grant per cycle, and rsp_id following the same order.
REQ-033 Masking: req=1111, mask=1010 -> only ids 1 and 3 are granted, alternating; gnt[0] and gnt[2] are never high.
REQ-034 frame_start with ptr=2 and req=1111 -> no grant that cycle, and the next grant goes to id 0; the previous in-flight response is still delivered.
REQ-035 rst_n low one cycle after a grant -> rsp_valid stays 0 through ROM_LAT+2 cycles after release, and all outputs are 0.
REQ-036 With SPRITE_FETCH_ARBITER_PERF_EN defined: 10 cycles with req=0011 and mask=1111 -> conflict_cnt=10; a following frame_start -> 0.

Source files
------------

// File: rtl/sprite_arb_pkg.sv
// ---------------------------------------------------------------------------
// sprite_arb_pkg
// Shared constants and types for the sprite fetch arbiter.
//   N_REQ      : number of sprite requesters (guy + three trophies)
//   AW         : sprite ROM address width (18x18 = 324 words)
//   DW         : pixel width, RGB444
//   ID_W       : width of a requester id
//   REQ_GUY, REQ_TROPHY0..2 : requester slot numbers
//   id_t       : requester id type
// ---------------------------------------------------------------------------
package sprite_arb_pkg;

    localparam int N_REQ = 4;
    localparam int AW    = 9;
    localparam int DW    = 12;
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam int REQ_GUY     = 0;
    localparam int REQ_TROPHY0 = 1;
    localparam int REQ_TROPHY1 = 2;
    localparam int REQ_TROPHY2 = 3;

    typedef logic [ID_W-1:0] id_t;

endpackage

// File: rtl/sprite_fetch_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. The search starts at ptr_i and
// wraps from N-1 back to 0; the first eligible slot found wins.
// Ports:
//   elig_i : eligible requesters (already masked / qualified)
//   ptr_i  : search start position
//   gnt_o  : one-hot grant (all zero when nothing is eligible)
//   idx_o  : index of the granted slot (0 when nothing is eligible)
//   any_o  : a grant was made
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  elig_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int off = 0; off < N; off++) begin
            int j;
            j = int'(ptr_i) + off;
            // ptr never exceeds N-1, so a single subtraction is a full wrap
            if (j >= N) j = j - N;
            if (!any_o && elig_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_fetch_arbiter
// Round-robin arbiter sharing one sprite ROM between the guy and trophy
// sprite engines. One grant per cycle, registered ROM port, and the owner id
// rides a ROM_LAT-deep pipeline so each returned pixel is tagged.
// Ports:
//   clk, rst_n            : pixel clock, async active-low reset
//   req, req_addr         : per-requester request and packed ROM address
//   req_mask              : per-requester enable (0 blocks grants)
//   frame_start           : vsync pulse, rewinds the pointer, no grant
//   gnt                   : combinational one-hot grant
//   rom_en, rom_addr      : registered shared-ROM read port
//   rom_data              : ROM read data, ROM_LAT cycles after rom_en
//   rsp_valid/id/data     : fetched pixel with owner id
//   conflict_cnt          : only with SPRITE_FETCH_ARBITER_PERF_EN defined;
//                           saturating count of cycles with >=2 eligible
//                           requesters pending, cleared by frame_start
// ---------------------------------------------------------------------------
module sprite_fetch_arbiter #(
    parameter  int N_REQ   = sprite_arb_pkg::N_REQ,
    parameter  int AW      = sprite_arb_pkg::AW,
    parameter  int DW      = sprite_arb_pkg::DW,
    parameter  int ROM_LAT = 1,
    localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ-1:0]    req_mask,
    input  logic                frame_start,
`ifdef SPRITE_FETCH_ARBITER_PERF_EN
    output logic [15:0]         conflict_cnt,
`endif
    output logic [N_REQ-1:0]    gnt,
    output logic                rom_en,
    output logic [AW-1:0]       rom_addr,
    input  logic [DW-1:0]       rom_data,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [DW-1:0]       rsp_data
);

    import sprite_arb_pkg::*;

    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] elig;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_any;

    logic             rom_en_q;
    logic [AW-1:0]    rom_addr_q;
    logic [IDW-1:0]   rom_id_q;

    logic [ROM_LAT-1:0] vld_q;
    logic [IDW-1:0]     id_pipe_q [ROM_LAT];
    logic [DW-1:0]      data_hold_q;

    assign pending = req & req_mask;
    assign elig    = frame_start ? '0 : pending;

    rr_pick #(
        .N  (N_REQ),
        .IW (IDW)
    ) u_pick (
        .elig_i (elig),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx),
        .any_o  (gnt_any)
    );

    // frame_start rewinds the search; otherwise advance past the winner
    always_comb begin
        ptr_d = ptr_q;
        if (frame_start)
            ptr_d = '0;
        else if (gnt_any)
            ptr_d = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            rom_id_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rom_en_q <= gnt_any;
            if (gnt_any) begin
                rom_addr_q <= req_addr[gnt_idx*AW +: AW];
                rom_id_q   <= gnt_idx;
            end
        end
    end

    // Id stages load only behind a valid entry, so the last stage keeps the
    // most recent delivered id while the pipeline is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            data_hold_q <= '0;
            for (int k = 0; k < ROM_LAT; k++) id_pipe_q[k] <= '0;
        end else begin
            vld_q[0] <= rom_en_q;
            if (rom_en_q) id_pipe_q[0] <= rom_id_q;
            for (int k = 1; k < ROM_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) id_pipe_q[k] <= id_pipe_q[k-1];
            end
            if (vld_q[ROM_LAT-1]) data_hold_q <= rom_data;
        end
    end

    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign rsp_valid = vld_q[ROM_LAT-1];
    assign rsp_id    = id_pipe_q[ROM_LAT-1];
    // ROM data lands in the response cycle itself; hold the last pixel after
    assign rsp_data  = rsp_valid ? rom_data : data_hold_q;

`ifdef SPRITE_FETCH_ARBITER_PERF_EN
    logic [15:0] conflict_q;

    // Contention is judged on pending requests, even in a frame_start cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            conflict_q <= '0;
        else if (frame_start)
            conflict_q <= '0;
        else if (($countones(pending) >= 2) && (conflict_q != 16'hFFFF))
            conflict_q <= conflict_q + 16'd1;
    end

    assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_fetch_arbiter
// Directed bench for sprite_fetch_arbiter with a small latency-accurate ROM
// model. Define SPRITE_FETCH_ARBITER_PERF_EN to also exercise conflict_cnt.
// ---------------------------------------------------------------------------
module tb_sprite_fetch_arbiter;

    localparam int NREQ   = 4;
    localparam int AWID   = 9;
    localparam int DWID   = 12;
    localparam int ROMLAT = 1;

    logic                 clk;
    logic                 rstN;
    logic [NREQ-1:0]      req;
    logic [NREQ*AWID-1:0] reqAddr;
    logic [NREQ-1:0]      reqMask;
    logic                 frameStart;
    logic [NREQ-1:0]      gnt;
    logic                 romEn;
    logic [AWID-1:0]      romAddr;
    logic [DWID-1:0]      romData;
    logic                 rspValid;
    logic [1:0]           rspId;
    logic [DWID-1:0]      rspData;
`ifdef SPRITE_FETCH_ARBITER_PERF_EN
    logic [15:0]          conflictCnt;
`endif

    int checks = 0;
    int errors = 0;

    sprite_fetch_arbiter #(
        .N_REQ   (NREQ),
        .AW      (AWID),
        .DW      (DWID),
        .ROM_LAT (ROMLAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rstN),
        .req          (req),
        .req_addr     (reqAddr),
        .req_mask     (reqMask),
        .frame_start  (frameStart),
`ifdef SPRITE_FETCH_ARBITER_PERF_EN
        .conflict_cnt (conflictCnt),
`endif
        .gnt          (gnt),
        .rom_en       (romEn),
        .rom_addr     (romAddr),
        .rom_data     (romData),
        .rsp_valid    (rspValid),
        .rsp_id       (rspId),
        .rsp_data     (rspData)
    );

    // 40 ns pixel clock
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Pixel stored at a ROM address: tag bits above the address
    function automatic logic [DWID-1:0] romWord(input logic [AWID-1:0] a);
        return {3'b101, a};
    endfunction

    // ROM model: reads return ROMLAT cycles after rom_en, junk otherwise
    logic [DWID-1:0] romPipe [ROMLAT];
    always @(posedge clk) begin
        romPipe[0] <= romEn ? romWord(romAddr) : 12'hBAD;
        for (int k = 1; k < ROMLAT; k++) romPipe[k] <= romPipe[k-1];
    end
    assign romData = romPipe[ROMLAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] m, input logic fs);
        req        = r;
        reqMask    = m;
        frameStart = fs;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN       = 1'b0;
        req        = '0;
        reqMask    = '0;
        frameStart = 1'b0;
        reqAddr    = {9'h000, 9'h000, 9'h000, 9'h005};
        nextCycle();
        nextCycle();

        // Reset state
        checkOutput("rst gnt", 32'(gnt), 32'h0);
        checkOutput("rst rom_en", 32'(romEn), 32'h0);
        checkOutput("rst rom_addr", 32'(romAddr), 32'h0);
        checkOutput("rst rsp_valid", 32'(rspValid), 32'h0);
        checkOutput("rst rsp_id", 32'(rspId), 32'h0);
        checkOutput("rst rsp_data", 32'(rspData), 32'h0);
        rstN = 1'b1;
        nextCycle();

        // Single request from the guy
        applyStimulus(4'b0001, 4'b1111, 1'b0);
        checkOutput("single gnt", 32'(gnt), 32'h1);
        nextCycle();
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        checkOutput("single rom_en", 32'(romEn), 32'h1);
        checkOutput("single rom_addr", 32'(romAddr), 32'h005);
        checkOutput("single early valid", 32'(rspValid), 32'h0);
        nextCycle();
        checkOutput("single rsp_valid", 32'(rspValid), 32'h1);
        checkOutput("single rsp_id", 32'(rspId), 32'h0);
        checkOutput("single rsp_data", 32'(rspData), 32'(romWord(9'h005)));
        checkOutput("single idle rom_en", 32'(romEn), 32'h0);
        checkOutput("single rom_addr hold", 32'(romAddr), 32'h005);
        nextCycle();
        checkOutput("hold rsp_valid", 32'(rspValid), 32'h0);
        checkOutput("hold rsp_id", 32'(rspId), 32'h0);
        checkOutput("hold rsp_data", 32'(rspData), 32'(romWord(9'h005)));

        // Rewind the pointer, then all four requesting continuously
        reqAddr = {9'h013, 9'h012, 9'h011, 9'h010};
        applyStimulus(4'b0000, 4'b1111, 1'b1);
        nextCycle();
        for (int k = 0; k < 10; k++) begin
            applyStimulus((k < 8) ? 4'b1111 : 4'b0000, 4'b1111, 1'b0);
            checkOutput("rr gnt", 32'(gnt), (k < 8) ? (32'h1 << (k % 4)) : 32'h0);
            if (k >= 2) begin
                checkOutput("rr rsp_valid", 32'(rspValid), 32'h1);
                checkOutput("rr rsp_id", 32'(rspId), 32'((k - 2) % 4));
                checkOutput("rr rsp_data", 32'(rspData), 32'(romWord(9'(9'h010 + (k - 2) % 4))));
            end
            nextCycle();
        end

        // Masking: only trophy0 and trophy2 may win, alternating
        for (int k = 0; k < 8; k++) begin
            applyStimulus((k < 6) ? 4'b1111 : 4'b0000, 4'b1010, 1'b0);
            if (k < 6)
                checkOutput("mask gnt", 32'(gnt), (k % 2 == 0) ? 32'h2 : 32'h8);
            else
                checkOutput("mask idle gnt", 32'(gnt), 32'h0);
            if (k >= 2)
                checkOutput("mask rsp_id", 32'(rspId), (k % 2 == 0) ? 32'h1 : 32'h3);
            nextCycle();
        end

        // frame_start with ptr=2 and an in-flight fetch for id 1
        applyStimulus(4'b0011, 4'b1111, 1'b0);
        checkOutput("fs pre gnt0", 32'(gnt), 32'h1);
        nextCycle();
        checkOutput("fs pre gnt1", 32'(gnt), 32'h2);
        nextCycle();
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        checkOutput("fs gnt suppressed", 32'(gnt), 32'h0);
        checkOutput("fs rom_en", 32'(romEn), 32'h1);
        checkOutput("fs rom_addr", 32'(romAddr), 32'h011);
        nextCycle();
        applyStimulus(4'b1111, 4'b1111, 1'b0);
        checkOutput("fs next gnt", 32'(gnt), 32'h1);
        checkOutput("fs inflight valid", 32'(rspValid), 32'h1);
        checkOutput("fs inflight id", 32'(rspId), 32'h1);
        checkOutput("fs inflight data", 32'(rspData), 32'(romWord(9'h011)));
        nextCycle();
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        nextCycle();
        nextCycle();

        // Mask drops while trophy1 is pending, then returns
        applyStimulus(4'b0100, 4'b1011, 1'b0);
        checkOutput("maskdrop gnt a", 32'(gnt), 32'h0);
        nextCycle();
        checkOutput("maskdrop gnt b", 32'(gnt), 32'h0);
        checkOutput("maskdrop rom_en", 32'(romEn), 32'h0);
        nextCycle();
        applyStimulus(4'b0100, 4'b1111, 1'b0);
        checkOutput("maskback gnt", 32'(gnt), 32'h4);
        nextCycle();
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        nextCycle();
        nextCycle();

        // Reset one cycle after a grant discards the fetch
        applyStimulus(4'b0001, 4'b1111, 1'b0);
        checkOutput("prerst gnt", 32'(gnt), 32'h1);
        nextCycle();
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        checkOutput("prerst rom_en", 32'(romEn), 32'h1);
        rstN = 1'b0;
        #1;
        checkOutput("midrst rom_en", 32'(romEn), 32'h0);
        checkOutput("midrst rom_addr", 32'(romAddr), 32'h0);
        checkOutput("midrst rsp_valid", 32'(rspValid), 32'h0);
        checkOutput("midrst rsp_id", 32'(rspId), 32'h0);
        checkOutput("midrst rsp_data", 32'(rspData), 32'h0);
        nextCycle();
        rstN = 1'b1;
        for (int k = 0; k < ROMLAT + 2; k++) begin
            nextCycle();
            checkOutput("postrst rsp_valid", 32'(rspValid), 32'h0);
            checkOutput("postrst rom_en", 32'(romEn), 32'h0);
            checkOutput("postrst rsp_data", 32'(rspData), 32'h0);
        end

        // First grant after reset goes to the lowest eligible index
        applyStimulus(4'b1010, 4'b1111, 1'b0);
        checkOutput("first gnt", 32'(gnt), 32'h2);
        nextCycle();
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        nextCycle();
        nextCycle();

`ifdef SPRITE_FETCH_ARBITER_PERF_EN
        applyStimulus(4'b0000, 4'b1111, 1'b1);
        nextCycle();
        checkOutput("perf cleared", 32'(conflictCnt), 32'h0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b0011, 4'b1111, 1'b0);
            nextCycle();
        end
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        checkOutput("perf count", 32'(conflictCnt), 32'd10);
        applyStimulus(4'b0000, 4'b1111, 1'b1);
        nextCycle();
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        checkOutput("perf fs clear", 32'(conflictCnt), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
